// File: rtl/axi_lite_bram_master.sv
`default_nettype none
//==============================================================================
// Module   : axi_lite_bram_master
// Purpose  : Bridges a simple word-addressed request/response port onto an
//            AXI-lite master. A local engine (DMA, debug unit, boot loader)
//            issues one request at a time. A non-zero byte-enable mask makes
//            it a write; a zero mask makes it a read. The block runs the
//            matching AXI-lite transaction and returns one response.
//
// Ports    : clk, rstn           clock; asynchronous active-low reset
//            req_valid/req_ready request handshake (req_ready = idle)
//            req_addr            word address
//            req_we              byte write enables (0 = read)
//            req_wdata           write data
//            rsp_valid/rsp_ready response handshake
//            rsp_rdata           read data (0 for writes)
//            rsp_err             xRESP[1] of the completed beat, or timeout
//            aw_*, w_*, b_*,     AXI-lite master channels. The slave's
//            ar_*, r_*           interface is flattened into plain ports.
//
// Config   : Define AXI_LITE_BRAM_MASTER_TIMEOUT_EN to enable the wait-cycle
//            watchdog (TIMEOUT_CYCLES). Without it the block waits forever
//            for the slave.
//
// Revision : 1.0 - initial release
//==============================================================================
module axi_lite_bram_master #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 16,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    // local request / response port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_we,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    // AXI-lite write address channel
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    output logic [2:0]                aw_prot,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    // AXI-lite write data channel
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic                      w_valid,
    input  logic                      w_ready,
    // AXI-lite write response channel
    input  logic [1:0]                b_resp,
    input  logic                      b_valid,
    output logic                      b_ready,
    // AXI-lite read address channel
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    output logic [2:0]                ar_prot,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    // AXI-lite read data channel
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_valid,
    output logic                      r_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_BITS  = $clog2(STRB_WIDTH);

    //--------------------------------------------------------------------------
    // Elaboration-time parameter checks
    //--------------------------------------------------------------------------
    generate
        if (ADDR_WIDTH + BYTE_BITS > AXI_ADDR_WIDTH) begin : g_addr_width_check
            $fatal(1, "axi_lite_bram_master: ADDR_WIDTH + log2(bytes) exceeds AXI_ADDR_WIDTH");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
            $fatal(1, "axi_lite_bram_master: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_WAIT_B = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RSP    = 3'd5,
        ST_DRAIN  = 3'd6
    } state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [STRB_WIDTH-1:0]     r_strb;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_aw_valid;
    logic                      r_w_valid;
    logic                      r_ar_valid;
    logic                      r_b_ready;
    logic                      r_r_ready;
    logic                      r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;

    // Byte address of the incoming request, zero-extended to the AXI width.
    logic [AXI_ADDR_WIDTH-1:0] w_req_byte_addr;
    assign w_req_byte_addr = AXI_ADDR_WIDTH'(req_addr) << BYTE_BITS;

    // Channel handshakes seen at the coming clock edge.
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    assign w_aw_hs = r_aw_valid & aw_ready;
    assign w_w_hs  = r_w_valid  & w_ready;
    assign w_ar_hs = r_ar_valid & ar_ready;
    assign w_b_hs  = r_b_ready  & b_valid;
    assign w_r_hs  = r_r_ready  & r_valid;

    // A write's address/data leg is finished once its valid is already low
    // or is being accepted now; the two legs may complete in either order.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = ~r_aw_valid | aw_ready;
    assign w_w_done  = ~r_w_valid  | w_ready;

    // Only the error bit of the response code matters: OKAY and EXOKAY both
    // report success.
    logic w_unused_resp;
    assign w_unused_resp = b_resp[0] ^ r_resp[0];

`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_WIDTH-1:0] r_wait_cnt;
    logic                 r_is_write;
    logic                 w_timeout;
    assign w_timeout = (r_wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

    //--------------------------------------------------------------------------
    // Transaction FSM. All slave-facing signals come from registers, so there
    // is no combinational path from req_* to the AXI side.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_strb      <= '0;
            r_wdata     <= '0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_b_ready   <= 1'b0;
            r_r_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_is_write  <= 1'b0;
`endif
        end else begin
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
            // Cleared on every state change; wait states override this.
            r_wait_cnt <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= w_req_byte_addr;
                        r_strb  <= req_we;
                        r_wdata <= req_wdata;
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                        r_is_write <= (req_we != '0);
`endif
                        if (req_we != '0) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= ST_WR;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_RD;
                        end
                    end
                end

                ST_WR: begin
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WAIT_B;
                    end
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_b_ready   <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                ST_RD: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_WAIT_R;
                    end
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_r_ready   <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                ST_WAIT_B: begin
                    if (w_b_hs) begin
                        r_b_ready   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= b_resp[1];
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RSP;
                    end
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                ST_WAIT_R: begin
                    if (w_r_hs) begin
                        r_r_ready   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_resp[1];
                        r_rsp_rdata <= r_data;
                        r_state     <= ST_RSP;
                    end
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
                // The error response is already offered; the abandoned AXI
                // transaction still has to finish so the slave is not left
                // mid-handshake. Its late B/R beat is swallowed.
                ST_DRAIN: begin
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if (w_ar_hs) r_ar_valid <= 1'b0;
                    if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
                    if (w_b_hs || w_r_hs) begin
                        r_b_ready <= 1'b0;
                        r_r_ready <= 1'b0;
                        r_state   <= (r_rsp_valid && !rsp_ready) ? ST_RSP : ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign req_ready = (r_state == ST_IDLE);

    assign aw_addr   = r_addr;
    assign aw_prot   = 3'b000;
    assign aw_valid  = r_aw_valid;
    assign w_data    = r_wdata;
    assign w_strb    = r_strb;
    assign w_valid   = r_w_valid;
    assign b_ready   = r_b_ready;
    assign ar_addr   = r_addr;
    assign ar_prot   = 3'b000;
    assign ar_valid  = r_ar_valid;
    assign r_ready   = r_r_ready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_bram_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_lite_bram_master
// Purpose  : Directed self-checking bench for axi_lite_bram_master. A small
//            configurable AXI-lite slave (per-channel ready delays, response
//            codes, read data) answers the DUT. Each scenario task drives a
//            request and compares against hand-computed values.
// Revision : 1.0 - initial release
//==============================================================================
module tb_axi_lite_bram_master;

    localparam int DW  = 64;
    localparam int AW  = 16;
    localparam int XAW = 32;
    localparam int SW  = DW / 8;
    localparam int TO  = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [AW-1:0]  req_addr  = '0;
    logic [SW-1:0]  req_we    = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;

    logic [XAW-1:0] aw_addr;
    logic [2:0]     aw_prot;
    logic           aw_valid;
    logic           aw_ready = 1'b0;
    logic [DW-1:0]  w_data;
    logic [SW-1:0]  w_strb;
    logic           w_valid;
    logic           w_ready  = 1'b0;
    logic [1:0]     b_resp   = 2'b00;
    logic           b_valid  = 1'b0;
    logic           b_ready;
    logic [XAW-1:0] ar_addr;
    logic [2:0]     ar_prot;
    logic           ar_valid;
    logic           ar_ready = 1'b0;
    logic [DW-1:0]  r_data   = '0;
    logic [1:0]     r_resp   = 2'b00;
    logic           r_valid  = 1'b0;
    logic           r_ready;

    axi_lite_bram_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .AXI_ADDR_WIDTH (XAW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .aw_addr   (aw_addr),
        .aw_prot   (aw_prot),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .ar_addr   (ar_addr),
        .ar_prot   (ar_prot),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_valid   (r_valid),
        .r_ready   (r_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    //--------------------------------------------------------------------------
    // Slave model. Evaluated on the falling edge: first retires handshakes
    // that completed on the last rising edge, then decides what to present
    // for the next one. A delay of -1 means "never ready".
    //--------------------------------------------------------------------------
    int          aw_delay   = 0;
    int          w_delay    = 0;
    int          ar_delay   = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [DW-1:0] r_data_cfg = '0;

    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0;
    bit aw_hs_p = 0, w_hs_p = 0, ar_hs_p = 0, b_hs_p = 0, r_hs_p = 0;
    int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;

    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
        end else begin
            if (aw_hs_p) begin aw_ready = 0; aw_got = 1; n_aw++; end
            if (w_hs_p)  begin w_ready  = 0; w_got  = 1; n_w++;  end
            if (ar_hs_p) begin ar_ready = 0; ar_got = 1; n_ar++; end
            if (b_hs_p)  begin b_valid  = 0; n_b++; end
            if (r_hs_p)  begin r_valid  = 0; n_r++; end

            if (aw_valid && !aw_ready) begin
                if (aw_delay >= 0 && aw_cnt >= aw_delay) begin aw_ready = 1; aw_cnt = 0; end
                else aw_cnt++;
            end
            if (w_valid && !w_ready) begin
                if (w_delay >= 0 && w_cnt >= w_delay) begin w_ready = 1; w_cnt = 0; end
                else w_cnt++;
            end
            if (ar_valid && !ar_ready) begin
                if (ar_delay >= 0 && ar_cnt >= ar_delay) begin ar_ready = 1; ar_cnt = 0; end
                else ar_cnt++;
            end

            if (aw_got && w_got && !b_valid) begin
                b_valid = 1; b_resp = b_resp_cfg; aw_got = 0; w_got = 0;
            end
            if (ar_got && !r_valid) begin
                r_valid = 1; r_resp = r_resp_cfg; r_data = r_data_cfg; ar_got = 0;
            end

            aw_hs_p = aw_valid && aw_ready;
            w_hs_p  = w_valid  && w_ready;
            ar_hs_p = ar_valid && ar_ready;
            b_hs_p  = b_valid  && b_ready;
            r_hs_p  = r_valid  && r_ready;
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers. do_req presents a request at the next falling edge
    // (acceptance cycle 0) and returns on the falling edge of cycle 1.
    //--------------------------------------------------------------------------
    task automatic do_req(input logic [AW-1:0] a, input logic [SW-1:0] we,
                          input logic [DW-1:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = '0;
    endtask

    // Waits (bounded) for rsp_valid; lat is the cycle offset from acceptance,
    // or -1 if no response arrived.
    task automatic wait_rsp(input int start, output int lat);
        int off;
        off = start;
        while (!rsp_valid && off < start + 40) begin
            @(negedge clk);
            off++;
        end
        lat = rsp_valid ? off : -1;
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset;
        n_cmp++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl: got %b want 0000000",
                     {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err});
        end
        n_cmp++;
        if (rsp_rdata !== 64'h0) begin
            n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_basic;
        int lat;
        int b0;
        b0 = n_b;
        do_req(16'h0012, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        n_cmp++;
        if ({aw_valid, w_valid, ar_valid} !== 3'b110) begin
            n_fail++; $display("FAIL wr_valids_c1: got %b want 110", {aw_valid, w_valid, ar_valid});
        end
        n_cmp++;
        if (aw_addr !== 32'h0000_0090) begin
            n_fail++; $display("FAIL wr_aw_addr: got %h want 00000090", aw_addr);
        end
        n_cmp++;
        if ({w_strb, aw_prot} !== {8'hFF, 3'b000}) begin
            n_fail++; $display("FAIL wr_strb_prot: got %h/%b want ff/000", w_strb, aw_prot);
        end
        n_cmp++;
        if (w_data !== 64'hDEADBEEF_CAFEF00D) begin
            n_fail++; $display("FAIL wr_w_data: got %h want deadbeefcafef00d", w_data);
        end
        wait_rsp(1, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL wr_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if ({rsp_err, rsp_rdata} !== {1'b0, 64'h0}) begin
            n_fail++; $display("FAIL wr_rsp: got err=%b data=%h want err=0 data=0", rsp_err, rsp_rdata);
        end
        consume;
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL wr_back_idle: got %b want 10", {req_ready, rsp_valid});
        end
        n_cmp++;
        if (n_b - b0 !== 1) begin
            n_fail++; $display("FAIL wr_b_count: got %0d want 1", n_b - b0);
        end
    endtask

    task automatic test_read_basic;
        int lat;
        r_data_cfg = 64'h1122334455667788;
        r_resp_cfg = 2'b00;
        do_req(16'h0012, 8'h00, 64'h0);
        n_cmp++;
        if ({aw_valid, w_valid, ar_valid} !== 3'b001) begin
            n_fail++; $display("FAIL rd_valids_c1: got %b want 001", {aw_valid, w_valid, ar_valid});
        end
        n_cmp++;
        if ({ar_addr, ar_prot} !== {32'h0000_0090, 3'b000}) begin
            n_fail++; $display("FAIL rd_ar_addr: got %h/%b want 00000090/000", ar_addr, ar_prot);
        end
        wait_rsp(1, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL rd_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if ({rsp_err, rsp_rdata} !== {1'b0, 64'h1122334455667788}) begin
            n_fail++; $display("FAIL rd_rsp: got err=%b data=%h want err=0 data=1122334455667788",
                               rsp_err, rsp_rdata);
        end
        consume;
    endtask

    task automatic test_w_before_aw;
        int lat;
        int b0, aw0, w0;
        b0 = n_b; aw0 = n_aw; w0 = n_w;
        aw_delay = 5;
        do_req(16'h0003, 8'h0F, 64'h0123456789ABCDEF);
        n_cmp++;
        if ({aw_valid, w_valid, aw_addr} !== {2'b11, 32'h0000_0018}) begin
            n_fail++; $display("FAIL wa_c1: got %b/%h want 11/00000018", {aw_valid, w_valid}, aw_addr);
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({aw_valid, w_valid} !== 2'b10) begin
                n_fail++; $display("FAIL wa_hold_c%0d: got %b want 10", k, {aw_valid, w_valid});
            end
        end
        wait_rsp(6, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL wa_latency: got %0d want 8", lat);
        end
        consume;
        n_cmp++;
        if ({n_aw - aw0, n_w - w0, n_b - b0} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL wa_counts: got aw=%0d w=%0d b=%0d want 1/1/1",
                               n_aw - aw0, n_w - w0, n_b - b0);
        end
        aw_delay = 0;
    endtask

    task automatic test_resp_codes;
        int lat;
        r_resp_cfg = 2'b10;
        r_data_cfg = 64'h0F0F_0F0F_0F0F_0F0F;
        do_req(16'h0040, 8'h00, 64'h0);
        wait_rsp(1, lat);
        n_cmp++;
        if ({lat == 3, rsp_err} !== 2'b11) begin
            n_fail++; $display("FAIL rc_rd_slverr: got lat=%0d err=%b want lat=3 err=1", lat, rsp_err);
        end
        consume;
        b_resp_cfg = 2'b01;
        do_req(16'h0041, 8'h01, 64'h55);
        wait_rsp(1, lat);
        n_cmp++;
        if ({lat == 3, rsp_err} !== 2'b10) begin
            n_fail++; $display("FAIL rc_wr_exokay: got lat=%0d err=%b want lat=3 err=0", lat, rsp_err);
        end
        consume;
        b_resp_cfg = 2'b10;
        do_req(16'h0042, 8'h80, 64'hAA);
        wait_rsp(1, lat);
        n_cmp++;
        if ({lat == 3, rsp_err} !== 2'b11) begin
            n_fail++; $display("FAIL rc_wr_slverr: got lat=%0d err=%b want lat=3 err=1", lat, rsp_err);
        end
        consume;
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b00;
    endtask

    task automatic test_backpressure;
        int lat;
        r_data_cfg = 64'hA5A5_0000_FFFF_1234;
        do_req(16'h0007, 8'h00, 64'h0);
        wait_rsp(1, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 3", lat);
        end
        // A second request waits while the first response is stalled.
        req_valid = 1'b1; req_addr = 16'h0008; req_we = '0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {3'b100, 64'hA5A5_0000_FFFF_1234}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b e=%b rdy=%b d=%h want v=1 e=0 rdy=0 d=a5a50000ffff1234",
                                   i, rsp_valid, rsp_err, req_ready, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bp_next_accept: got %b want 10", {req_ready, rsp_valid});
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({ar_valid, ar_addr} !== {1'b1, 32'h0000_0040}) begin
            n_fail++; $display("FAIL bp_second_ar: got %b/%h want 1/00000040", ar_valid, ar_addr);
        end
        wait_rsp(1, lat);
        n_cmp++;
        if ({lat == 3, rsp_rdata} !== {1'b1, 64'hA5A5_0000_FFFF_1234}) begin
            n_fail++; $display("FAIL bp_second_rsp: got lat=%0d d=%h want lat=3 d=a5a50000ffff1234", lat, rsp_rdata);
        end
        consume;
    endtask

    task automatic test_reset_mid;
        int lat;
        ar_delay = -1;
        do_req(16'h0005, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if (ar_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_pending: got %b want 1", ar_valid);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({ar_valid, r_ready, rsp_valid, req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL rm_async: got %b want 0001", {ar_valid, r_ready, rsp_valid, req_ready});
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        ar_delay = 0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_no_rsp: got %b want 0", rsp_valid);
        end
        r_data_cfg = 64'h5555_6666_7777_8888;
        do_req(16'h0006, 8'h00, 64'h0);
        wait_rsp(1, lat);
        n_cmp++;
        if ({lat == 3, rsp_rdata} !== {1'b1, 64'h5555_6666_7777_8888}) begin
            n_fail++; $display("FAIL rm_recover: got lat=%0d d=%h want lat=3 d=5555666677778888", lat, rsp_rdata);
        end
        consume;
    endtask

`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int  r0;
        bit  spurious;
        bit  idle_seen;
        ar_delay = -1;
        do_req(16'h0021, 8'h00, 64'h0);
        n_cmp++;
        if (ar_valid !== 1'b1) begin
            n_fail++; $display("FAIL to_ar_c1: got %b want 1", ar_valid);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_early: got %b want 0 at cycle 16", rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_err, ar_valid, req_ready, rsp_rdata} !== {4'b1110, 64'h0}) begin
            n_fail++; $display("FAIL to_rsp: got v=%b e=%b ar=%b rdy=%b d=%h want 1/1/1/0/0",
                               rsp_valid, rsp_err, ar_valid, req_ready, rsp_rdata);
        end
        consume;
        n_cmp++;
        if ({rsp_valid, ar_valid, req_ready, r_ready} !== 4'b0101) begin
            n_fail++; $display("FAIL to_drain: got %b want 0101", {rsp_valid, ar_valid, req_ready, r_ready});
        end
        r0 = n_r;
        ar_delay = 0;
        spurious = 0;
        idle_seen = 0;
        for (int i = 0; i < 10 && !idle_seen; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious = 1;
            if (req_ready) idle_seen = 1;
        end
        @(negedge clk);
        n_cmp++;
        if ({idle_seen, spurious} !== 2'b10) begin
            n_fail++; $display("FAIL to_drain_exit: got idle=%b rsp=%b want idle=1 rsp=0", idle_seen, spurious);
        end
        n_cmp++;
        if (n_r - r0 !== 1) begin
            n_fail++; $display("FAIL to_late_r: got %0d want 1", n_r - r0);
        end
    endtask
`endif

    //--------------------------------------------------------------------------
    // Sequencer
    //--------------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rstn = 1'b1;
        @(negedge clk);
        test_write_basic;
        test_read_basic;
        test_w_before_aw;
        test_resp_codes;
        test_backpressure;
        test_reset_mid;
`ifdef AXI_LITE_BRAM_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
